kaipokrandt_fsm_control: RTL and testbench
==========================================

Name: kaipokrandt_fsm_control

Overview:
Instruction dispatcher and initiator for the per-instruction execution FSMs (MOVI, MOV, ALU).
- Accepts 16-bit instructions over a valid/ready handshake and decodes them.
- Issues a one-cycle start with held decode flags, then waits for the selected unit's done.
- Retires the instruction, or flags halt, illegal opcode or timeout.
- Sits between instruction fetch and the execution FSMs.

Parameters:
TIMEOUT, 16, max WAIT cycles before a missing done is an error (must be >= 2).
CNT_W, 5, width of the timeout counter (must hold TIMEOUT).

Ports:
clk  input  1  system clock, rising edge.
reset  input  1  asynchronous, active-low reset.
instr_valid  input  1  fetch presents instr.
instr  input  16  [15:12] opcode, [11:8] dst, [7:4] src, [7:0] imm.
instr_ready  output  1  dispatcher can accept an instruction.
done_movi  input  1  MOVI FSM done.
done_mov  input  1  MOV FSM done.
done_alu  input  1  ALU FSM done.
start  output  1  one-cycle issue pulse to the execution FSMs.
dec_movi  output  1  MOVI selected.
dec_mov  output  1  MOV selected.
dec_alu  output  1  ADD/SUB selected.
alu_sub  output  1  1=SUB, 0=ADD (valid with dec_alu).
uses_imm  output  1  instruction carries an immediate (MOVI).
imm  output  8  latched immediate.
dst_sel  output  4  latched destination register.
src_sel  output  4  latched source register.
busy  output  1  instruction in flight.
retire  output  1  one-cycle pulse, instruction completed.
halted  output  1  sticky, HALT executed.
err  output  1  sticky error.
err_code  output  2  01 illegal opcode, 10 timeout, 00 none.

Behaviour:
- Reset: one clock; reset is asynchronous and active-low. Reset forces state IDLE and clears IR, counter, the retire flag and err_code.
  - Reset values: instr_ready=1, all other outputs 0.
  - Reset mid-operation abandons the instruction; no retire is produced.
- Opcodes: 0x0 NOP, 0x1 MOVI, 0x2 MOV, 0x3 ADD, 0x4 SUB, 0xF HALT. All others are illegal.
- IDLE: instr_ready=1. On instr_valid && instr_ready at a clock edge, latch instr into IR and go to DECODE.
- DECODE (1 cycle): busy=1.
  - NOP -> IDLE, with retire in the next cycle.
  - HALT -> HALTED.
  - Illegal -> ERROR with err_code=01.
  - Otherwise -> ISSUE.
- ISSUE (1 cycle): start=1, busy=1. Load counter with TIMEOUT, go to WAIT.
- WAIT: busy=1, start=0.
  - Only the selected unit's done is honoured (MOVI->done_movi, MOV->done_mov, ADD/SUB->done_alu). Non-selected dones are ignored.
  - Done is sampled only in WAIT; a done during ISSUE is ignored.
  - On selected done -> IDLE, with retire=1 in the first IDLE cycle.
  - Each WAIT cycle without done decrements the counter. After TIMEOUT WAIT cycles with no done -> ERROR with err_code=10.
  - A done in the final (TIMEOUT-th) WAIT cycle wins over timeout.
- Held outputs: dec_*, alu_sub, uses_imm, imm, dst_sel and src_sel are driven from IR and valid from ISSUE through the last WAIT cycle.
  - They are 0 in IDLE, DECODE, HALTED and ERROR.
  - imm, dst_sel and src_sel hold their IR value in all states but are meaningful only with dec_*.
- Back-to-back: the retire cycle is an IDLE cycle with instr_ready=1, so a new instruction may be accepted in the same cycle as retire.
- HALTED: halted=1, instr_ready=0. Sticky until reset.
- ERROR: err=1, err_code held, instr_ready=0. Sticky until reset.
- No combinational path from instr_valid to instr_ready.

Test Plan:
- MOVI 0x1A5C accepted at edge E0 → DECODE, start=1 in ISSUE with dec_movi=1, uses_imm=1, imm=0x5C, dst_sel=0xA; done_movi pulsed 2 cycles after start → retire=1 exactly one cycle after done, busy=0, instr_ready=1.
- SUB 0x4320 then ADD 0x3210 presented back-to-back, each done_alu 1 cycle after start → alu_sub=1 then 0, dec_alu=1, two retire pulses; second instr accepted in first retire cycle.
- MOV in WAIT, done_movi and done_alu pulsed (wrong units), then done_mov → only done_mov retires; start pulses exactly once.
- MOV with no done for TIMEOUT=16 WAIT cycles → err=1, err_code=10, instr_ready=0 held; done_mov exactly in 16th WAIT cycle (separate run) → retire, no error.
- Opcode 0x7 → err_code=01 after DECODE, no start; HALT 0xF000 → halted=1, instr_ready stays 0 despite instr_valid.
- reset low during WAIT of MOVI → all outputs 0 except instr_ready=1, no retire; after release, NOP 0x0000 → retire in the cycle after DECODE, start never asserted.

Source files
------------

// File: rtl/kaipokrandt_fsm_control.sv
// kaipokrandt_fsm_control
// Instruction dispatcher for the MOVI / MOV / ALU execution FSMs.
// An instruction is accepted over a valid/ready handshake and decoded.
// The dispatcher then issues a one-cycle start with held decode flags and
// waits for the selected unit's done. It then retires the instruction, or
// flags halt, an illegal opcode or a timeout.
//
// Ports
//   clk          system clock, rising edge
//   reset        asynchronous, active-low reset
//   instr_valid  fetch presents instr
//   instr[15:0]  [15:12] opcode, [11:8] dst, [7:4] src, [7:0] imm
//   instr_ready  dispatcher can accept an instruction
//   done_movi    MOVI FSM done
//   done_mov     MOV FSM done
//   done_alu     ALU FSM done
//   start        one-cycle issue pulse to the execution FSMs
//   dec_movi     MOVI selected (ISSUE..WAIT)
//   dec_mov      MOV selected (ISSUE..WAIT)
//   dec_alu      ADD/SUB selected (ISSUE..WAIT)
//   alu_sub      1=SUB, 0=ADD, valid with dec_alu
//   uses_imm     instruction carries an immediate (MOVI)
//   imm[7:0]     latched immediate
//   dst_sel[3:0] latched destination register
//   src_sel[3:0] latched source register
//   busy         instruction in flight
//   retire       one-cycle pulse, instruction completed
//   halted       sticky, HALT executed
//   err          sticky error
//   err_code     01 illegal opcode, 10 timeout, 00 none
module kaipokrandt_fsm_control #(
    parameter int unsigned TIMEOUT = 16,
    parameter int unsigned CNT_W   = 5
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        instr_valid,
    input  logic [15:0] instr,
    output logic        instr_ready,
    input  logic        done_movi,
    input  logic        done_mov,
    input  logic        done_alu,
    output logic        start,
    output logic        dec_movi,
    output logic        dec_mov,
    output logic        dec_alu,
    output logic        alu_sub,
    output logic        uses_imm,
    output logic [7:0]  imm,
    output logic [3:0]  dst_sel,
    output logic [3:0]  src_sel,
    output logic        busy,
    output logic        retire,
    output logic        halted,
    output logic        err,
    output logic [1:0]  err_code
);

    localparam logic [3:0] OP_NOP  = 4'h0;
    localparam logic [3:0] OP_MOVI = 4'h1;
    localparam logic [3:0] OP_MOV  = 4'h2;
    localparam logic [3:0] OP_ADD  = 4'h3;
    localparam logic [3:0] OP_SUB  = 4'h4;
    localparam logic [3:0] OP_HALT = 4'hF;

    typedef enum logic [2:0] {
        S_IDLE,
        S_DECODE,
        S_ISSUE,
        S_WAIT,
        S_HALTED,
        S_ERROR
    } state_t;

    state_t             state_q, state_d;
    logic [15:0]        ir_q;
    logic               ir_load;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               retire_q, retire_d;
    logic [1:0]         code_q, code_d;

    logic [3:0]         op;
    logic               is_movi, is_mov, is_alu, is_sub;
    logic               done_sel;
    logic               held;

    assign op      = ir_q[15:12];
    assign is_movi = (op == OP_MOVI);
    assign is_mov  = (op == OP_MOV);
    assign is_sub  = (op == OP_SUB);
    assign is_alu  = (op == OP_ADD) || is_sub;

    // Only the unit that owns the latched opcode may complete it.
    assign done_sel = (is_movi && done_movi) ||
                      (is_mov  && done_mov)  ||
                      (is_alu  && done_alu);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q  <= S_IDLE;
            ir_q     <= '0;
            cnt_q    <= '0;
            retire_q <= 1'b0;
            code_q   <= '0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            retire_q <= retire_d;
            code_q   <= code_d;
            if (ir_load) begin
                ir_q <= instr;
            end
        end
    end

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        retire_d = 1'b0;
        code_d   = code_q;
        ir_load  = 1'b0;
        unique case (state_q)
            S_IDLE: begin
                // instr_ready is exactly "state is IDLE", so it stays a
                // registered-state decode with no path from instr_valid.
                if (instr_valid) begin
                    ir_load = 1'b1;
                    state_d = S_DECODE;
                end
            end
            S_DECODE: begin
                unique case (op)
                    OP_NOP: begin
                        state_d  = S_IDLE;
                        retire_d = 1'b1;
                    end
                    OP_HALT: state_d = S_HALTED;
                    OP_MOVI, OP_MOV, OP_ADD, OP_SUB: state_d = S_ISSUE;
                    default: begin
                        state_d = S_ERROR;
                        code_d  = 2'b01;
                    end
                endcase
            end
            S_ISSUE: begin
                cnt_d   = CNT_W'(TIMEOUT);
                state_d = S_WAIT;
            end
            S_WAIT: begin
                // Done is tested before the counter so a done in the last
                // WAIT cycle still retires.
                if (done_sel) begin
                    state_d  = S_IDLE;
                    retire_d = 1'b1;
                end else if (cnt_q == CNT_W'(1)) begin
                    state_d = S_ERROR;
                    code_d  = 2'b10;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            S_HALTED: state_d = S_HALTED;
            S_ERROR:  state_d = S_ERROR;
            default:  state_d = S_IDLE;
        endcase
    end

    assign held        = (state_q == S_ISSUE) || (state_q == S_WAIT);

    assign instr_ready = (state_q == S_IDLE);
    assign start       = (state_q == S_ISSUE);
    assign busy        = (state_q == S_DECODE) || held;
    assign retire      = retire_q;
    assign halted      = (state_q == S_HALTED);
    assign err         = (state_q == S_ERROR);
    assign err_code    = code_q;

    assign dec_movi    = held && is_movi;
    assign dec_mov     = held && is_mov;
    assign dec_alu     = held && is_alu;
    assign alu_sub     = held && is_sub;
    assign uses_imm    = held && is_movi;

    assign imm         = ir_q[7:0];
    assign dst_sel     = ir_q[11:8];
    assign src_sel     = ir_q[7:4];

endmodule

// File: tb/tb_kaipokrandt_fsm_control.sv
// Self-checking bench for kaipokrandt_fsm_control: a directed vector table,
// hand-written reset sequences, and randomized instructions whose expected
// outcome comes from an opcode-level model.
module tb_kaipokrandt_fsm_control;

    localparam int T = 16;

    logic        clk = 1'b0;
    logic        reset;
    logic        instr_valid;
    logic [15:0] instr;
    logic        instr_ready;
    logic        done_movi, done_mov, done_alu;
    logic        start, dec_movi, dec_mov, dec_alu, alu_sub, uses_imm;
    logic [7:0]  imm;
    logic [3:0]  dst_sel, src_sel;
    logic        busy, retire, halted, err;
    logic [1:0]  err_code;

    int checks = 0;
    int errors = 0;

    kaipokrandt_fsm_control #(.TIMEOUT(T), .CNT_W(5)) dut (
        .clk(clk), .reset(reset), .instr_valid(instr_valid), .instr(instr),
        .instr_ready(instr_ready), .done_movi(done_movi), .done_mov(done_mov),
        .done_alu(done_alu), .start(start), .dec_movi(dec_movi),
        .dec_mov(dec_mov), .dec_alu(dec_alu), .alu_sub(alu_sub),
        .uses_imm(uses_imm), .imm(imm), .dst_sel(dst_sel), .src_sel(src_sel),
        .busy(busy), .retire(retire), .halted(halted), .err(err),
        .err_code(err_code)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

    // dec = {movi, mov, alu, sub, uses_imm}; k = WAIT cycle of selected done,
    // k > T means no done at all.
    typedef struct {
        logic [15:0] instr;
        int          k;
        logic [4:0]  dec;
        logic        halt;
        logic [1:0]  code;
        logic        noise;
    } vec_t;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [12:0] outs();
        return {instr_ready, start, busy, retire, halted, err, err_code,
                dec_movi, dec_mov, dec_alu, alu_sub, uses_imm};
    endfunction

    function automatic logic [12:0] ev(input logic rdy, input logic st, input logic bsy,
                                       input logic ret, input logic hlt, input logic er,
                                       input logic [1:0] code, input logic [4:0] dec);
        return {rdy, st, bsy, ret, hlt, er, code, dec};
    endfunction

    // Opcode-level reference: what the instruction should select and how it ends.
    function automatic vec_t model(input logic [15:0] ins, input int k, input logic noise);
        vec_t v;
        v.instr = ins; v.k = k; v.dec = '0; v.halt = 1'b0; v.code = 2'b00; v.noise = noise;
        case (ins[15:12])
            4'h0: ;
            4'h1: v.dec = 5'b10001;
            4'h2: v.dec = 5'b01000;
            4'h3: v.dec = 5'b00100;
            4'h4: v.dec = 5'b00110;
            4'hF: v.halt = 1'b1;
            default: v.code = 2'b01;
        endcase
        if (v.dec != 5'b0 && k > T) v.code = 2'b10;
        return v;
    endfunction

    task automatic drive_done(input logic [4:0] d, input logic sel, input logic noise);
        done_movi = d[4] ? sel : (noise & $urandom_range(1, 0) == 1);
        done_mov  = d[3] ? sel : (noise & $urandom_range(1, 0) == 1);
        done_alu  = d[2] ? sel : (noise & $urandom_range(1, 0) == 1);
    endtask

    task automatic do_reset();
        reset = 1'b0;
        instr_valid = 1'b0;
        done_movi = 1'b0; done_mov = 1'b0; done_alu = 1'b0;
        #2;
        chk("reset_outs", outs(), ev(1, 0, 0, 0, 0, 0, 2'b00, 5'b0));
        chk("reset_fields", {imm, dst_sel, src_sel}, 16'h0);
        step();
        step();
        reset = 1'b1;
    endtask

    // Starts in a cycle where the DUT should be IDLE; ends in the retire cycle
    // (still IDLE) so the next call is a back-to-back accept.
    task automatic run_one(input vec_t v);
        logic [4:0] d;
        d = v.dec;
        chk("idle_ready", instr_ready, 1);
        instr = v.instr;
        instr_valid = 1'b1;
        step();
        instr_valid = 1'b0;
        instr = 16'($urandom);
        chk("decode", outs(), ev(0, 0, 1, 0, 0, 0, 2'b00, 5'b0));
        if (v.halt) begin
            step();
            chk("halted", outs(), ev(0, 0, 0, 0, 1, 0, 2'b00, 5'b0));
            instr_valid = 1'b1;
            repeat (3) begin
                step();
                chk("halt_sticky", outs(), ev(0, 0, 0, 0, 1, 0, 2'b00, 5'b0));
            end
            instr_valid = 1'b0;
            return;
        end
        if (v.code == 2'b01) begin
            step();
            chk("illegal", outs(), ev(0, 0, 0, 0, 0, 1, 2'b01, 5'b0));
            instr_valid = 1'b1;
            repeat (2) begin
                step();
                chk("illegal_sticky", outs(), ev(0, 0, 0, 0, 0, 1, 2'b01, 5'b0));
            end
            instr_valid = 1'b0;
            return;
        end
        if (d == 5'b0) begin
            step();
            chk("nop_retire", outs(), ev(1, 0, 0, 1, 0, 0, 2'b00, 5'b0));
            return;
        end
        step();
        chk("issue", outs(), ev(0, 1, 1, 0, 0, 0, 2'b00, d));
        chk("issue_fields", {imm, dst_sel, src_sel},
            {v.instr[7:0], v.instr[11:8], v.instr[7:4]});
        // A done in ISSUE must be ignored.
        if (v.noise) drive_done(d, 1'b1, 1'b1);
        for (int w = 1; w <= T; w++) begin
            step();
            drive_done(d, w == v.k, v.noise);
            chk("wait", outs(), ev(0, 0, 1, 0, 0, 0, 2'b00, d));
            if (w == v.k) begin
                step();
                drive_done(5'b0, 1'b0, 1'b0);
                chk("retire", outs(), ev(1, 0, 0, 1, 0, 0, 2'b00, 5'b0));
                return;
            end
        end
        step();
        drive_done(5'b0, 1'b0, 1'b0);
        chk("timeout", outs(), ev(0, 0, 0, 0, 0, 1, v.code, 5'b0));
        instr_valid = 1'b1;
        repeat (2) begin
            step();
            chk("timeout_sticky", outs(), ev(0, 0, 0, 0, 0, 1, v.code, 5'b0));
        end
        instr_valid = 1'b0;
    endtask

    task automatic run_and_recover(input vec_t v);
        run_one(v);
        if (v.halt || v.code != 2'b00) do_reset();
    endtask

    initial begin
        vec_t tbl[10];
        vec_t v;
        logic [3:0] op;
        int k;

        reset = 1'b0;
        instr_valid = 1'b0;
        instr = '0;
        done_movi = 1'b0; done_mov = 1'b0; done_alu = 1'b0;

        tbl[0] = '{16'h1A5C, 2,     5'b10001, 1'b0, 2'b00, 1'b0};
        tbl[1] = '{16'h4320, 1,     5'b00110, 1'b0, 2'b00, 1'b0};
        tbl[2] = '{16'h3210, 1,     5'b00100, 1'b0, 2'b00, 1'b0};
        tbl[3] = '{16'h2345, 4,     5'b01000, 1'b0, 2'b00, 1'b1};
        tbl[4] = '{16'h2000, T,     5'b01000, 1'b0, 2'b00, 1'b1};
        tbl[5] = '{16'h0000, 0,     5'b00000, 1'b0, 2'b00, 1'b0};
        tbl[6] = '{16'h1FFF, 1,     5'b10001, 1'b0, 2'b00, 1'b1};
        tbl[7] = '{16'h2111, T + 1, 5'b01000, 1'b0, 2'b10, 1'b1};
        tbl[8] = '{16'h7000, 0,     5'b00000, 1'b0, 2'b01, 1'b0};
        tbl[9] = '{16'hF000, 0,     5'b00000, 1'b1, 2'b00, 1'b0};

        do_reset();
        for (int i = 0; i < 10; i++) run_and_recover(tbl[i]);

        // Reset while a MOVI waits: instruction is abandoned, no retire.
        instr = 16'h1A5C;
        instr_valid = 1'b1;
        step();
        instr_valid = 1'b0;
        step();
        step();
        step();
        chk("pre_reset_wait", outs(), ev(0, 0, 1, 0, 0, 0, 2'b00, 5'b10001));
        reset = 1'b0;
        #2;
        chk("midop_reset", outs(), ev(1, 0, 0, 0, 0, 0, 2'b00, 5'b0));
        step();
        reset = 1'b1;
        step();
        chk("after_reset_no_retire", outs(), ev(1, 0, 0, 0, 0, 0, 2'b00, 5'b0));
        run_one(model(16'h0000, 0, 1'b0));

        // Randomized instructions against the opcode-level model.
        for (int i = 0; i < 60; i++) begin
            case ($urandom_range(9, 0))
                8:       op = 4'hF;
                9:       op = 4'($urandom_range(14, 5));
                default: op = 4'($urandom_range(4, 0));
            endcase
            k = ($urandom_range(7, 0) == 0) ? T + 1 : int'($urandom_range(T, 1));
            v = model({op, 12'($urandom)}, k, 1'($urandom));
            run_and_recover(v);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
